skid_reg: RTL and testbench

- Handshaked pipeline register: the consumer-facing counterpart of the plain datapath register.
- Upstream producer pushes with in_valid/in_ready; downstream consumer pops with out_valid/out_ready.
- Two-entry skid buffer, so full throughput (1 word/cycle) is sustained while in_ready stays a registered-state function (no combinational ready path from out_ready to in_ready).
- Sits between generated datapath stages when a stage can stall.

---
 rtl/skid_reg_pkg.sv | 11 +
 rtl/skid_reg_dreg.sv | 17 +
 rtl/skid_reg.sv | 92 +++++++++
 tb/tb_skid_reg.sv | 134 +++++++++++++
 4 files changed

// File: rtl/skid_reg_pkg.sv
// Shared state encoding for the skid_reg handshake register.
// Occupancy (count) reuses these numeric values directly.
package skid_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_t;

endpackage

// File: rtl/skid_reg_dreg.sv
// Plain data register with synchronous active-high reset; 1-cycle latency, no backpressure.
// Enable is applied by the parent, which feeds back q through its d mux.
module skid_reg_dreg #(
  parameter int WIDTH = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge Clk) begin
    if (Rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/skid_reg.sv
// Two-entry skid buffer: a pushed word shows on q the cycle after its push edge.
// in_ready depends only on registered state and Rst, so out_ready never reaches it combinationally.
module skid_reg #(
  parameter int DATAWIDTH = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] d,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           count
);

  import skid_reg_pkg::*;

  state_t               state_q;
  state_t               state_d;
  logic                 push;
  logic                 pop;
  logic                 load_q;
  logic                 q_from_skid;
  logic                 load_skid;
  logic [DATAWIDTH-1:0] skid_q;
  logic [DATAWIDTH-1:0] skid_d;

  assign in_ready  = (state_q != FULL) & ~Rst;
  assign out_valid = (state_q != EMPTY);
  assign count     = (state_q == FULL) ? 2'd2 :
                     (state_q == BUSY) ? 2'd1 : 2'd0;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    load_q      = 1'b0;
    q_from_skid = 1'b0;
    load_skid   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (push) begin
          load_q  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (push && pop) begin
          load_q = 1'b1;
        end else if (push) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          load_q      = 1'b1;
          q_from_skid = 1'b1;
          state_d     = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // q loads from either the input or the skid entry, so it stays inline.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= EMPTY;
      q       <= '0;
    end else begin
      state_q <= state_d;
      if (load_q) q <= q_from_skid ? skid_q : d;
    end
  end

  assign skid_d = load_skid ? d : skid_q;

  skid_reg_dreg #(
    .WIDTH (DATAWIDTH)
  ) u_skid (
    .Clk (Clk),
    .Rst (Rst),
    .d   (skid_d),
    .q   (skid_q)
  );

endmodule

// File: tb/tb_skid_reg.sv
// Directed plus randomized bench for skid_reg against a queue-based occupancy model.
module tb_skid_reg;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic [W-1:0] d = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] q;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [1:0]   count;

  int n_checks = 0;
  int n_errs   = 0;

  logic [W-1:0] m_q[$];
  logic [W-1:0] m_qval = '0;

  skid_reg #(.DATAWIDTH(W)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .d         (d),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs after negedge, compare against model, then advance model at posedge.
  task automatic step(input logic r, input logic iv, input logic [W-1:0] dd, input logic ordy);
    logic do_push;
    logic do_pop;
    @(negedge Clk);
    Rst = r; in_valid = iv; d = dd; out_ready = ordy;
    #1;
    check("in_ready", in_ready, (!r && m_q.size() < 2));
    check("out_valid", out_valid, (m_q.size() > 0));
    check("count", count, m_q.size());
    check("q", q, m_qval);
    @(posedge Clk);
    if (r) begin
      m_q.delete();
      m_qval = '0;
    end else begin
      do_push = iv && (m_q.size() < 2);
      do_pop  = ordy && (m_q.size() > 0);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(dd);
      if (m_q.size() > 0) m_qval = m_q[0];
    end
  endtask

  task automatic expect_regs(input string tag, input logic [W-1:0] eq, input logic ev, input logic [1:0] ec);
    #1;
    check({tag, "_q"}, q, eq);
    check({tag, "_vld"}, out_valid, ev);
    check({tag, "_cnt"}, count, ec);
  endtask

  initial begin
    repeat (2) @(posedge Clk);

    // reset held with traffic pending
    step(1'b1, 1'b1, 8'hAA, 1'b0);
    step(1'b1, 1'b1, 8'hAA, 1'b0);
    expect_regs("rst", 8'h00, 1'b0, 2'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // single pass-through
    step(1'b0, 1'b1, 8'h11, 1'b0);
    expect_regs("pass", 8'h11, 1'b1, 2'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    expect_regs("drain", 8'h11, 1'b0, 2'd0);

    // full throughput
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b1, W'(i), 1'b1);
      expect_regs("thru", W'(i), 1'b1, 2'd1);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // stall into skid, blocked third word, then ordered drain
    step(1'b0, 1'b1, 8'h21, 1'b0);
    step(1'b0, 1'b1, 8'h22, 1'b0);
    expect_regs("full", 8'h21, 1'b1, 2'd2);
    step(1'b0, 1'b1, 8'h23, 1'b0);
    step(1'b0, 1'b1, 8'h23, 1'b0);
    expect_regs("blocked", 8'h21, 1'b1, 2'd2);
    step(1'b0, 1'b1, 8'h23, 1'b1);
    expect_regs("skid_out", 8'h22, 1'b1, 2'd1);
    step(1'b0, 1'b1, 8'h23, 1'b1);
    expect_regs("third", 8'h23, 1'b1, 2'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // simultaneous push+pop while busy
    step(1'b0, 1'b1, 8'h30, 1'b0);
    step(1'b0, 1'b1, 8'h31, 1'b1);
    expect_regs("pushpop", 8'h31, 1'b1, 2'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // reset while full discards both words
    step(1'b0, 1'b1, 8'h40, 1'b0);
    step(1'b0, 1'b1, 8'h41, 1'b0);
    expect_regs("full2", 8'h40, 1'b1, 2'd2);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    expect_regs("midrst", 8'h00, 1'b0, 2'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           W'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
